// File: rtl/seg_display_scheduler_pkg.sv
// Shared types and constants for the 4-digit display scheduler.
// Char codes are active-low {g,f,e,d,c,b,a}; anodes active-low.
package seg_display_scheduler_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_e;

  localparam logic [6:0] SEG_N     = 7'h2B;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_P     = 7'h0C;
  localparam logic [6:0] SEG_X     = 7'h09;
  localparam logic [6:0] SEG_O     = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [3:0] AN_D0  = 4'b0111;
  localparam logic [3:0] AN_D1  = 4'b1011;
  localparam logic [3:0] AN_D2  = 4'b1101;
  localparam logic [3:0] AN_D3  = 4'b1110;

  localparam int unsigned REQ_WIN   = 0;
  localparam int unsigned REQ_TURN  = 1;
  localparam int unsigned REQ_ERR   = 2;
  localparam int unsigned REQ_IDLE  = 3;

  function automatic logic [3:0] an_pattern(
    input logic [1:0] d
  );
    logic [3:0] p;
    p = AN_OFF;
    unique case (d)
      2'd0: p = AN_D0;
      2'd1: p = AN_D1;
      2'd2: p = AN_D2;
      2'd3: p = AN_D3;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Digit-slot divider: counts 0..DIV-1, tick high while at DIV-1.
// Ports: clk, rst (sync, active-high) in; tick out (1 clk wide).
module seg_tick_gen #(
  parameter int unsigned DIV = 65536
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] MAX = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == MAX) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == MAX);

endmodule

// File: rtl/seg_display_scheduler.sv
// Scans a 4-digit 7-seg display and shares it among 4 requesters
// with fixed priority, minimum hold and frame-boundary swaps.
// Ports: clk, rst (sync, active-high), req[3:0] (bit0 highest),
//   msg[111:0] (28b per requester, char0 in top 7b), blink[3:0] in;
//   seg[6:0], an[3:0] (active-low), grant[3:0] one-hot, busy out.
module seg_display_scheduler #(
  parameter int unsigned REFRESH_DIV  = 65536,
  parameter int unsigned HOLD_FRAMES  = 64,
  parameter int unsigned BLINK_FRAMES = 96
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [111:0] msg,
  input  logic [3:0]   blink,
  output logic [6:0]   seg,
  output logic [3:0]   an,
  output logic [3:0]   grant,
  output logic         busy
);

  import seg_display_scheduler_pkg::*;

  localparam int unsigned HW =
    (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam int unsigned BW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic tick;

  seg_tick_gen #(
    .DIV (REFRESH_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  state_e        state_q, state_d;
  logic [3:0]    owner_q, owner_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [27:0]   shadow_q, shadow_d;
  logic          sblink_q, sblink_d;
  logic          phase_q, phase_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [1:0]    digit_q, digit_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;

  logic          frame_end;
  logic          keep;
  logic [3:0]    pick;
  logic [3:0]    tgt;
  logic [27:0]   sel_msg;
  logic          sel_blink;
  logic [6:0]    chr;
  logic          lit;

  assign frame_end = tick & (digit_q == 2'd3);
  assign keep      = (|(owner_q & req)) & (hold_q != '0);
  // lowest set bit = highest priority requester
  assign pick      = req & (~req + 4'd1);
  assign tgt       = keep ? owner_q : pick;

  // content of whoever owns the next frame
  always_comb begin
    sel_msg   = '0;
    sel_blink = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (tgt[i]) begin
        sel_msg   = msg[28*i +: 28];
        sel_blink = blink[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      hold_q   <= '0;
      shadow_q <= {4{SEG_BLANK}};
      sblink_q <= 1'b0;
      phase_q  <= 1'b1;
      bcnt_q   <= '0;
      digit_q  <= '0;
      seg_q    <= SEG_BLANK;
      an_q     <= AN_OFF;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      hold_q   <= hold_d;
      shadow_q <= shadow_d;
      sblink_q <= sblink_d;
      phase_q  <= phase_d;
      bcnt_q   <= bcnt_d;
      digit_q  <= digit_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    hold_d   = hold_q;
    shadow_d = shadow_q;
    sblink_d = sblink_q;
    phase_d  = phase_q;
    bcnt_d   = bcnt_q;
    digit_d  = tick ? digit_q + 2'd1 : digit_q;
    if (frame_end) begin
      if (keep) begin
        hold_d = hold_q - 1'b1;
      end else if (|req) begin
        owner_d = pick;
        state_d = ST_SHOW;
        // self re-grant leaves hold untouched
        if (pick != owner_q) begin
          hold_d = HW'(HOLD_FRAMES - 1);
        end
      end else begin
        owner_d = '0;
        state_d = ST_IDLE;
        hold_d  = '0;
      end
      shadow_d = (|tgt) ? sel_msg : {4{SEG_BLANK}};
      sblink_d = sel_blink;
      if (owner_d != owner_q) begin
        phase_d = 1'b1;
        bcnt_d  = '0;
      end else if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
        phase_d = ~phase_q;
        bcnt_d  = '0;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  // outputs follow the *next* frame state so a swap
  // lands exactly on the first digit of the new frame
  always_comb begin
    chr = SEG_BLANK;
    unique case (digit_d)
      2'd0: chr = shadow_d[27:21];
      2'd1: chr = shadow_d[20:14];
      2'd2: chr = shadow_d[13:7];
      2'd3: chr = shadow_d[6:0];
    endcase
    lit   = (state_d == ST_SHOW) & ~(sblink_d & ~phase_d);
    seg_d = seg_q;
    an_d  = an_q;
    if (tick) begin
      seg_d = lit ? chr : SEG_BLANK;
      an_d  = lit ? an_pattern(digit_d) : AN_OFF;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign grant = owner_q;
  assign busy  = (state_q == ST_SHOW);

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Randomised bench for seg_display_scheduler against a
// frame-level reference model (DIV=4, HOLD=2, BLINK=1).
module tb_seg_display_scheduler;

  localparam int DIV  = 4;
  localparam int HOLD = 2;
  localparam int BF   = 1;

  localparam logic [6:0] C_N = 7'h2B;
  localparam logic [6:0] C_E = 7'h06;
  localparam logic [6:0] C_R = 7'h2F;
  localparam logic [6:0] C_P = 7'h0C;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [111:0] msg;
  logic [3:0]   blink;
  logic [6:0]   seg;
  logic [3:0]   an;
  logic [3:0]   grant;
  logic         busy;

  seg_display_scheduler #(
    .REFRESH_DIV  (DIV),
    .HOLD_FRAMES  (HOLD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .msg   (msg),
    .blink (blink),
    .seg   (seg),
    .an    (an),
    .grant (grant),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // e = clock edges since reset released
  int         e;
  int         m_owner;
  int         m_hold;
  int         m_age;
  logic       m_blink;
  logic [6:0] m_chr [4];

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s e=%0d t=%0t got=%h want=%h",
               tag, e, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_hold  = 0;
    m_age   = 0;
    m_blink = 1'b0;
    for (int k = 0; k < 4; k++) m_chr[k] = 7'h7F;
  endtask

  task automatic model_frame_end();
    int pick;
    int prev;
    pick = -1;
    prev = m_owner;
    for (int i = 3; i >= 0; i--) if (req[i]) pick = i;
    if (m_owner >= 0 && req[m_owner] && m_hold > 0) begin
      m_hold--;
    end else if (pick >= 0) begin
      if (pick != m_owner) m_hold = HOLD - 1;
      m_owner = pick;
    end else begin
      m_owner = -1;
    end
    if (m_owner >= 0) begin
      for (int k = 0; k < 4; k++)
        m_chr[k] = msg[28*m_owner + 21 - 7*k +: 7];
      m_blink = blink[m_owner];
    end
    if (m_owner != prev) m_age = 0;
    else m_age++;
  endtask

  task automatic step();
    logic [3:0] x_an;
    logic [3:0] x_gr;
    logic [6:0] x_seg;
    logic       x_busy;
    int         d;
    bit         on;
    @(negedge clk);
    if (rst) begin
      model_reset();
      e = 0;
    end else begin
      e++;
      if (e % 16 == 0) model_frame_end();
    end
    x_an   = 4'hF;
    x_seg  = 7'h7F;
    x_gr   = 4'h0;
    x_busy = 1'b0;
    if (m_owner >= 0) begin
      x_gr   = 4'(1 << m_owner);
      x_busy = 1'b1;
      d      = (e / 4) % 4;
      on     = ((m_age / BF) % 2) == 0;
      if (on || !m_blink) begin
        x_an  = ~(4'b1000 >> d);
        x_seg = m_chr[d];
      end
    end
    check("seg",   32'(seg),   32'(x_seg));
    check("an",    32'(an),    32'(x_an));
    check("grant", 32'(grant), 32'(x_gr));
    check("busy",  32'(busy),  32'(x_busy));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst   = 1'b1;
    req   = 4'h0;
    msg   = '0;
    blink = 4'h0;
    step();
    step();
    rst = 1'b0;
    run(100);

    msg[56 +: 28] = {C_N, C_E, C_R, C_P};
    msg[0 +: 28]  = 28'($urandom);
    req = 4'b0100;
    run(38);
    req[0] = 1'b1;
    run(26);
    msg[56 +: 28] = {C_P, C_R, C_E, C_N};
    run(30);
    req = 4'b0100;
    run(37);
    req = 4'b0000;
    run(40);

    blink[2] = 1'b1;
    req = 4'b0100;
    run(83);
    rst = 1'b1;
    step();
    rst = 1'b0;
    blink = 4'h0;
    run(20);

    for (int c = 0; c < 4000; c++) begin
      step();
      if ($urandom_range(23) == 0)
        req[$urandom_range(3)] ^= 1'b1;
      if ($urandom_range(9) == 0)
        msg[28*$urandom_range(3) +: 28] = 28'($urandom);
      if ($urandom_range(39) == 0)
        blink[$urandom_range(3)] ^= 1'b1;
      if ($urandom_range(999) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
